chi_request_node: RTL and testbench

- Requester-side agent for the CHI home node: turns single CPU-side load/store requests into home-node read/write commands and returns the results to the CPU.
- Owns one local line (tag, data, valid). Read hits complete locally without home-node traffic.
- Writes are write-through.
- Sits between a core/test master and the home node's addr/command/write_data/request_valid/response_valid interface.

---
 rtl/chi_request_node.sv | 172 +++++++++++++++++
 tb/tb_chi_request_node.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/chi_request_node.sv
// chi_request_node: requester-side agent between a CPU-style master and the
// CHI home node. Holds one local line (tag/data/valid); read hits complete
// locally, everything else goes to the home node as a single request pulse.
// Writes are write-through and also refresh the local line on success.
module chi_request_node #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [3:0]  CMD_READ       = 4'b0001,
    parameter logic [3:0]  CMD_WRITE      = 4'b0010
) (
    input  logic        clk,
    input  logic        reset,
    // CPU side
    input  logic        cpu_req_valid,
    output logic        cpu_req_ready,
    input  logic        cpu_req_write,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_resp_valid,
    output logic [31:0] cpu_rdata,
    output logic        cpu_resp_error,
    input  logic        line_inv,
    // home-node side
    output logic [31:0] hn_addr,
    output logic [3:0]  hn_command,
    output logic [31:0] hn_write_data,
    output logic        hn_request_valid,
    input  logic [31:0] hn_read_data,
    input  logic        hn_response_valid
);

    // Last WAIT cycle index; a response in that same cycle still wins.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HIT,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic        wr_q, wr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        line_vld_q, line_vld_d;
    logic [29:0] line_tag_q, line_tag_d;
    logic [31:0] line_data_q, line_data_d;

    logic        read_hit;
    logic        hn_active;

    // Hit test against the incoming request (reads only).
    always_comb begin
        read_hit = !cpu_req_write && line_vld_q && (line_tag_q == cpu_addr[31:2]);
    end

    // Next-state, request latch, local line and response data.
    always_comb begin
        state_d     = state_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        line_vld_d  = line_vld_q;
        line_tag_d  = line_tag_q;
        line_data_d = line_data_q;

        case (state_q)
            S_IDLE: begin
                if (cpu_req_valid) begin
                    wr_d    = cpu_req_write;
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                    if (read_hit) begin
                        // Capture line data now so a same-cycle invalidate
                        // cannot disturb the hit response.
                        rdata_d = line_data_q;
                        err_d   = 1'b0;
                        state_d = S_HIT;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_HIT: begin
                state_d = S_IDLE;
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (hn_response_valid) begin
                    err_d       = 1'b0;
                    rdata_d     = wr_q ? 32'h0 : hn_read_data;
                    line_tag_d  = addr_q[31:2];
                    line_data_d = wr_q ? wdata_q : hn_read_data;
                    line_vld_d  = 1'b1;
                    state_d     = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    rdata_d = 32'h0;
                    // A failed write leaves the cached copy stale.
                    if (wr_q && (line_tag_q == addr_q[31:2])) begin
                        line_vld_d = 1'b0;
                    end
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Invalidate has priority over any fill in the same cycle.
        if (line_inv) begin
            line_vld_d = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            line_vld_q  <= 1'b0;
            line_tag_q  <= '0;
            line_data_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            line_vld_q  <= line_vld_d;
            line_tag_q  <= line_tag_d;
            line_data_q <= line_data_d;
        end
    end

    // Outputs decoded from state; home-node fields are held through WAIT.
    always_comb begin
        hn_active        = (state_q == S_ISSUE) || (state_q == S_WAIT);
        cpu_req_ready    = (state_q == S_IDLE) && reset;
        cpu_resp_valid   = (state_q == S_HIT) || (state_q == S_DONE);
        cpu_resp_error   = (state_q == S_DONE) && err_q;
        cpu_rdata        = rdata_q;
        hn_request_valid = (state_q == S_ISSUE);
        hn_addr          = hn_active ? addr_q : 32'h0;
        hn_command       = hn_active ? (wr_q ? CMD_WRITE : CMD_READ) : 4'h0;
        hn_write_data    = (hn_active && wr_q) ? wdata_q : 32'h0;
    end

endmodule

// File: tb/tb_chi_request_node.sv
// Bench for chi_request_node: directed vector table, reset corner case and
// randomized transactions checked against a one-line cache model.
module tb_chi_request_node;
    localparam int T = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_req_valid = 1'b0;
    logic        cpu_req_write = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic        line_inv = 1'b0;
    logic [31:0] hn_read_data = '0;
    logic        hn_response_valid = 1'b0;
    logic        cpu_req_ready, cpu_resp_valid, cpu_resp_error, hn_request_valid;
    logic [31:0] cpu_rdata, hn_addr, hn_write_data;
    logic [3:0]  hn_command;

    chi_request_node #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
        .cpu_req_write(cpu_req_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_resp_valid(cpu_resp_valid), .cpu_rdata(cpu_rdata),
        .cpu_resp_error(cpu_resp_error), .line_inv(line_inv),
        .hn_addr(hn_addr), .hn_command(hn_command), .hn_write_data(hn_write_data),
        .hn_request_valid(hn_request_valid), .hn_read_data(hn_read_data),
        .hn_response_valid(hn_response_valid)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: one line
    bit          mv;
    logic [29:0] mtag;
    logic [31:0] mdata;

    // Observed results of the last transaction
    bit          r_ready, r_got, r_after;
    int          r_lat, r_np;
    logic [31:0] r_rdata, r_haddr, r_hwdata, r_waddr, r_hold;
    logic        r_err;
    logic [3:0]  r_cmd;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] hn;
        int          dly;    // response in WAIT cycle dly; >= T means silent
        bit          inv;    // line_inv coincident with the response
        int          e_np;
        int          e_lat;
        logic [31:0] e_rdata;
        logic        e_err;
    } vec_t;

    vec_t vt[13];

    function automatic vec_t mk(input logic wr, input logic [31:0] addr, wdata, hn,
                                input int dly, input bit inv, input int np, lat,
                                input logic [31:0] rd, input logic er);
        vec_t v;
        v.wr = wr; v.addr = addr; v.wdata = wdata; v.hn = hn; v.dly = dly; v.inv = inv;
        v.e_np = np; v.e_lat = lat; v.e_rdata = rd; v.e_err = er;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one request and act as home-node responder until cpu_resp_valid.
    task automatic run_txn(input logic wr, input logic [31:0] addr, wdata, hn,
                           input int dly, input bit inv);
        int cyc;
        @(negedge clk);
        r_ready = cpu_req_ready;
        cpu_req_valid = 1'b1; cpu_req_write = wr; cpu_addr = addr; cpu_wdata = wdata;
        r_np = 0; r_got = 0; r_lat = -1; r_rdata = '0; r_err = 1'b0;
        r_cmd = '0; r_haddr = '0; r_hwdata = '0; r_waddr = '0;
        cyc = 0;
        while (!r_got && cyc < 64) begin
            @(negedge clk);
            cyc++;
            cpu_req_valid = 1'b0; hn_response_valid = 1'b0; line_inv = 1'b0;
            if (hn_request_valid) begin
                r_np++; r_cmd = hn_command; r_haddr = hn_addr; r_hwdata = hn_write_data;
            end
            if (cyc == 2) r_waddr = hn_addr;
            if (cpu_resp_valid) begin
                r_got = 1; r_lat = cyc; r_rdata = cpu_rdata; r_err = cpu_resp_error;
            end else if (cyc == 2 + dly) begin
                hn_response_valid = 1'b1; hn_read_data = hn; line_inv = inv;
            end
        end
        @(negedge clk);
        hn_response_valid = 1'b0; line_inv = 1'b0;
        r_after = cpu_resp_valid;
        r_hold = cpu_rdata;
        if (hn_request_valid) r_np++;
    endtask

    task automatic check_txn(input string nm, input logic wr, input logic [31:0] addr, wdata,
                             input int np, lat, input logic [31:0] rd, input logic er);
        check({nm, " ready"}, 32'(r_ready), 32'd1);
        check({nm, " resp_seen"}, 32'(r_got), 32'd1);
        check({nm, " latency"}, r_lat, lat);
        check({nm, " rdata"}, r_rdata, rd);
        check({nm, " error"}, 32'(r_err), 32'(er));
        check({nm, " req_pulses"}, r_np, np);
        check({nm, " resp_one_cycle"}, 32'(r_after), 32'd0);
        check({nm, " rdata_hold"}, r_hold, rd);
        if (np == 1) begin
            check({nm, " hn_command"}, 32'(r_cmd), wr ? 32'h2 : 32'h1);
            check({nm, " hn_addr"}, r_haddr, addr);
            check({nm, " hn_wdata"}, r_hwdata, wr ? wdata : 32'h0);
            check({nm, " hn_addr_held"}, r_waddr, addr);
        end
    endtask

    // Predict one transaction from the line rules and update the model.
    task automatic model_txn(input logic wr, input logic [31:0] addr, wdata, hn,
                             input int dly, input bit inv,
                             output int np, lat, output logic [31:0] rd, output logic er);
        bit hit;
        hit = !wr && mv && (mtag == addr[31:2]);
        if (hit) begin
            np = 0; lat = 1; rd = mdata; er = 1'b0;
        end else if (dly < T) begin
            np = 1; lat = 3 + dly; rd = wr ? 32'h0 : hn; er = 1'b0;
            mtag = addr[31:2]; mdata = wr ? wdata : hn; mv = !inv;
        end else begin
            np = 1; lat = 2 + T; rd = 32'h0; er = 1'b1;
            if (wr && mtag == addr[31:2]) mv = 0;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int np, lat, nresp, nreq;
        logic [31:0] rd;
        logic er;
        logic wr;
        logic [31:0] addr, wd, hn;
        int dly;
        bit inv;

        mv = 0; mtag = '0; mdata = '0;

        vt[0]  = mk(1, 32'h40,  32'hDEADBEEF, 32'h0,        0, 0, 1, 3,      32'h0,        0);
        vt[1]  = mk(0, 32'h42,  32'h0,        32'h0,        0, 0, 0, 1,      32'hDEADBEEF, 0);
        vt[2]  = mk(0, 32'h80,  32'h0,        32'h12345678, 0, 0, 1, 3,      32'h12345678, 0);
        vt[3]  = mk(0, 32'h80,  32'h0,        32'h0,        0, 0, 0, 1,      32'h12345678, 0);
        vt[4]  = mk(0, 32'h100, 32'h0,        32'h0,      255, 0, 1, 2 + T,  32'h0,        1);
        vt[5]  = mk(0, 32'h80,  32'h0,        32'h0,        0, 0, 0, 1,      32'h12345678, 0);
        vt[6]  = mk(0, 32'h200, 32'h0,        32'hCAFEF00D, 3, 1, 1, 6,      32'hCAFEF00D, 0);
        vt[7]  = mk(0, 32'h200, 32'h0,        32'h11112222, 0, 0, 1, 3,      32'h11112222, 0);
        vt[8]  = mk(1, 32'h200, 32'h0000A5A5, 32'h0,      255, 0, 1, 2 + T,  32'h0,        1);
        vt[9]  = mk(0, 32'h200, 32'h0,        32'h00003333, T - 1, 0, 1, 2 + T, 32'h00003333, 0);
        vt[10] = mk(0, 32'h204, 32'h0,        32'h00000044, 1, 0, 1, 4,      32'h00000044, 0);
        vt[11] = mk(1, 32'h204, 32'h00005555, 32'h0,        2, 0, 1, 5,      32'h0,        0);
        vt[12] = mk(0, 32'h206, 32'h0,        32'h0,        0, 0, 0, 1,      32'h00005555, 0);

        // Reset state: all outputs low while reset is held
        repeat (2) @(negedge clk);
        check("rst cpu_req_ready", 32'(cpu_req_ready), 32'd0);
        check("rst cpu_resp_valid", 32'(cpu_resp_valid), 32'd0);
        check("rst cpu_resp_error", 32'(cpu_resp_error), 32'd0);
        check("rst cpu_rdata", cpu_rdata, 32'h0);
        check("rst hn_request_valid", 32'(hn_request_valid), 32'd0);
        check("rst hn_addr", hn_addr, 32'h0);
        check("rst hn_command", 32'(hn_command), 32'h0);
        check("rst hn_write_data", hn_write_data, 32'h0);
        reset = 1'b1;

        // Directed vectors
        for (int i = 0; i < 13; i++) begin
            run_txn(vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].hn, vt[i].dly, vt[i].inv);
            check_txn($sformatf("vec%0d", i), vt[i].wr, vt[i].addr, vt[i].wdata,
                      vt[i].e_np, vt[i].e_lat, vt[i].e_rdata, vt[i].e_err);
            model_txn(vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].hn, vt[i].dly, vt[i].inv,
                      np, lat, rd, er);
        end

        // Reset in the middle of a read miss, then a stray response pulse
        @(negedge clk);
        cpu_req_valid = 1'b1; cpu_req_write = 1'b0; cpu_addr = 32'h300;
        @(negedge clk);
        cpu_req_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst cpu_req_ready", 32'(cpu_req_ready), 32'd0);
        check("midrst hn_addr", hn_addr, 32'h0);
        check("midrst hn_command", 32'(hn_command), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        hn_response_valid = 1'b1; hn_read_data = 32'hBAD0BAD0;
        nresp = 0; nreq = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            hn_response_valid = 1'b0;
            if (cpu_resp_valid) nresp++;
            if (hn_request_valid) nreq++;
        end
        check("midrst no_resp", nresp, 0);
        check("midrst no_req", nreq, 0);
        check("midrst ready", 32'(cpu_req_ready), 32'd1);
        mv = 0; mtag = '0; mdata = '0;
        // Line was 0x204 before reset; it must now miss
        model_txn(1'b0, 32'h204, 32'h0, 32'h0000ABCD, 0, 0, np, lat, rd, er);
        run_txn(1'b0, 32'h204, 32'h0, 32'h0000ABCD, 0, 0);
        check_txn("postrst", 1'b0, 32'h204, 32'h0, np, lat, rd, er);

        // Randomized transactions against the model
        for (int k = 0; k < 40; k++) begin
            wr   = ($urandom_range(0, 2) == 0);
            addr = 32'h1000 + (32'($urandom_range(0, 3)) << 2) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) addr = $urandom;
            wd   = $urandom;
            hn   = $urandom;
            case ($urandom_range(0, 9))
                0:       dly = 255;
                1:       dly = T - 1;
                2:       dly = T - 2;
                default: dly = int'($urandom_range(0, 4));
            endcase
            inv = ($urandom_range(0, 5) == 0);
            model_txn(wr, addr, wd, hn, dly, inv, np, lat, rd, er);
            run_txn(wr, addr, wd, hn, dly, inv);
            check_txn($sformatf("rnd%0d", k), wr, addr, wd, np, lat, rd, er);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
